// File: rtl/spi_slave.sv
// SPI mode-0 debug slave: MSB-first, fixed-width frames, clocked by the serial clock.
// Holds the last complete received byte and shifts out a locally supplied byte.
module spi_slave #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  in_sck,
  input  logic                  in_rst_n,
  input  logic                  in_cs_n,
  input  logic                  in_mosi,
  output logic                  o_miso,
  input  logic [DATA_WIDTH-1:0] in_dbg_byte,
  output logic [DATA_WIDTH-1:0] o_dbg_byte
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  last_bit;

  assign last_bit = (bit_cnt == LAST_BIT);

  always_ff @(posedge in_sck or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rx_shift   <= '0;
      tx_shift   <= '0;
      bit_cnt    <= '0;
      o_dbg_byte <= '0;
    end else if (in_cs_n) begin
      // Idle: keep the next transmit byte loaded so MISO is valid as soon as cs_n falls.
      bit_cnt  <= '0;
      tx_shift <= in_dbg_byte;
    end else begin
      rx_shift <= {rx_shift[DATA_WIDTH-3:0], in_mosi};
      if (last_bit) begin
        o_dbg_byte <= {rx_shift, in_mosi};
        bit_cnt    <= '0;
        tx_shift   <= in_dbg_byte;
      end else begin
        bit_cnt  <= bit_cnt + 1'b1;
        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  assign o_miso = in_cs_n ? 1'bz : tx_shift[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: scoreboard of expected received bytes,
// per-bit MISO checks against the byte loaded for each frame.
module tb_spi_slave;

  localparam int HALF = 5;

  logic       in_sck;
  logic       in_rst_n;
  logic       in_cs_n;
  logic       in_mosi;
  logic       o_miso;
  logic [7:0] in_dbg_byte;
  logic [7:0] o_dbg_byte;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_rx;

  spi_slave #(.DATA_WIDTH(8)) dut (
    .in_sck      (in_sck),
    .in_rst_n    (in_rst_n),
    .in_cs_n     (in_cs_n),
    .in_mosi     (in_mosi),
    .o_miso      (o_miso),
    .in_dbg_byte (in_dbg_byte),
    .o_dbg_byte  (o_dbg_byte)
  );

  initial in_sck = 1'b0;
  always #HALF in_sck = ~in_sck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge in_sck);
      in_cs_n = 1'b1;
    end
  endtask

  // Drives nbits of a frame; a full frame is pushed to the scoreboard and
  // checked after its last rising edge. chg_at changes in_dbg_byte mid-frame.
  task automatic frame(input logic [7:0] mosi, input int nbits, input logic [7:0] exp_miso,
                       input int chg_at, input logic [7:0] new_dbg);
    logic [7:0] exp;
    if (nbits == 8) exp_q.push_back(mosi);
    for (int b = 0; b < nbits; b++) begin
      @(negedge in_sck);
      in_cs_n = 1'b0;
      in_mosi = mosi[7-b];
      if (b == chg_at) in_dbg_byte = new_dbg;
      #2;
      check("miso_bit", {31'd0, o_miso}, {31'd0, exp_miso[7-b]});
      @(posedge in_sck);
      #1;
      if (b < 7) begin
        check("rx_hold", {24'd0, o_dbg_byte}, {24'd0, last_rx});
      end else if (exp_q.size() == 0) begin
        check("sb_empty", exp_q.size(), 1);
      end else begin
        exp = exp_q.pop_front();
        check("rx_byte", {24'd0, o_dbg_byte}, {24'd0, exp});
        last_rx = exp;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    in_rst_n    = 1'b1;
    in_cs_n     = 1'b1;
    in_mosi     = 1'b0;
    in_dbg_byte = 8'h00;
    last_rx     = 8'h00;

    // Reset while the clock runs
    @(negedge in_sck);
    in_rst_n = 1'b0;
    #1;
    check("rst_async", {24'd0, o_dbg_byte}, 32'h00);
    idle(3);
    #1;
    check("rst_hold", {24'd0, o_dbg_byte}, 32'h00);
    in_rst_n = 1'b1;
    idle(2);

    // Single frame A5, then cs_n high holds the byte
    frame(8'hA5, 8, 8'h00, -1, 8'h00);
    idle(3);
    #1;
    check("a5_after_cs", {24'd0, o_dbg_byte}, 32'hA5);

    // MISO with 3C loaded while idle
    in_dbg_byte = 8'h3C;
    idle(2);
    frame(8'h33, 8, 8'h3C, -1, 8'h00);
    idle(2);

    // Back-to-back frames, in_dbg_byte changes during the first one
    in_dbg_byte = 8'h96;
    idle(2);
    frame(8'h5A, 8, 8'h96, 3, 8'hC3);
    frame(8'hFF, 8, 8'hC3, -1, 8'h00);
    idle(2);
    #1;
    check("b2b_last", {24'd0, o_dbg_byte}, 32'hFF);

    // Abort after 4 bits, then a full frame
    in_dbg_byte = 8'h69;
    idle(2);
    frame(8'hF0, 4, 8'h69, -1, 8'h00);
    idle(2);
    #1;
    check("abort_hold", {24'd0, o_dbg_byte}, 32'hFF);
    frame(8'h81, 8, 8'h69, -1, 8'h00);
    idle(2);

    // Reset mid-frame after 5 bits
    in_dbg_byte = 8'hE7;
    idle(2);
    frame(8'h42, 5, 8'hE7, -1, 8'h00);
    @(negedge in_sck);
    in_rst_n = 1'b0;
    in_cs_n  = 1'b1;
    #1;
    check("rst_mid", {24'd0, o_dbg_byte}, 32'h00);
    last_rx = 8'h00;
    idle(2);
    in_rst_n = 1'b1;
    idle(2);
    frame(8'h7E, 8, 8'hE7, -1, 8'h00);
    idle(2);
    #1;
    check("post_rst_7e", {24'd0, o_dbg_byte}, 32'h7E);
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
